uart_tx_param: RTL and testbench

Parametrised UART transmitter and next-generation serial TX engine for the APB-UART subsystem. Features:
- Configurable character width and stop-bit count.
- Exact per-bit baud timing.
- Small TX FIFO, so the bus side can queue words while a frame is on the line.
- Back-to-back frames with no idle gap between them.

---
 rtl/uart_tx_param.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small TX FIFO.
//
// The bus side pushes words into the FIFO. A serialiser FSM pops them and
// sends each one as a frame: start bit, DATA_BITS data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. Every bit lasts exactly
// DIV = CLK_HZ/BAUD clocks. A word already waiting when a stop period ends
// is popped on that same edge, so consecutive frames have no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity_odd input and
// a parity bit after the data bits (even parity, or odd when parity_odd=1).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   tx_valid    bus offers a word
//   tx_data     word to send, sampled only on accept
//   parity_odd  (UART_TX_PARITY_EN only) parity sense, sampled at pop
//   tx_ready    FIFO can accept (not full), registered
//   tx_out      serial line, idle high, registered
//   busy        frame on the line or FIFO non-empty, registered
//   fifo_level  current FIFO occupancy 0..FIFO_DEPTH, registered
module uart_tx_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV   = CLK_HZ / BAUD;
  // Guarded widths keep declarations legal while the checks below report
  // an illegal configuration.
  localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_param: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Parity bit of a word: XOR of its bits, inverted for odd parity.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d,
                                     input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic [LVL_W-1:0]     level_s;
  logic                 push_s;
  logic                 pop_s;

  // Serialiser state
  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     baud_r;
  logic [CNT_W-1:0]     baud_s;
  logic [3:0]           bit_r;
  logic [3:0]           bit_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 bit_end_s;
  logic                 line_s;
`ifdef UART_TX_PARITY_EN
  logic                 par_r;
  logic                 par_s;
`endif

  // Registered outputs
  logic                 tx_out_r;
  logic                 busy_r;
  logic                 ready_r;

  assign push_s     = tx_valid && ready_r;
  assign tx_ready   = ready_r;
  assign tx_out     = tx_out_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

  // Next FIFO occupancy; a push and a pop on the same edge cancel out.
  always_comb begin
    level_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_W'(1);
      2'b01:   level_s = level_r - LVL_W'(1);
      default: level_s = level_r;
    endcase
  end

  // FIFO data array; not reset, stale contents are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and level; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_s;
    end
  end

  // Serialiser next-state logic and the line value for the next cycle.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s     = par_r;
`endif
    // The baud counter restarts on the first clock of every bit.
    bit_end_s = (baud_r == BAUD_LAST);

    case (state_r)
      IDLE: begin
        baud_s = '0;
        bit_s  = 4'd0;
        if (level_r != '0) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
          par_s   = parity_of(mem_r[rd_ptr_r], parity_odd);
`endif
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          baud_s  = '0;
          bit_s   = 4'd0;
          state_s = DATA;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end_s) begin
          baud_s  = '0;
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s   = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s   = bit_r + 4'd1;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          baud_s  = '0;
          bit_s   = 4'd0;
          state_s = STOP;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (bit_end_s) begin
          baud_s = '0;
          if (bit_r == STOP_LAST) begin
            bit_s = 4'd0;
            // Chain straight into the next frame when a word is waiting.
            if (level_r != '0) begin
              pop_s   = 1'b1;
              shift_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
              par_s   = parity_of(mem_r[rd_ptr_r], parity_odd);
`endif
              state_s = START;
            end else begin
              state_s = IDLE;
            end
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end

      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = 4'd0;
      end
    endcase

    // Line value is a function of the next state so the flop output
    // changes on the same edge the FSM enters a bit.
    case (state_s)
      START:   line_s = 1'b0;
      DATA:    line_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_s = par_s;
`endif
      default: line_s = 1'b1;
    endcase
  end

  // Serialiser registers and registered outputs; reset forces the line high
  // immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      baud_r   <= '0;
      bit_r    <= 4'd0;
      shift_r  <= '0;
`ifdef UART_TX_PARITY_EN
      par_r    <= 1'b0;
`endif
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
`ifdef UART_TX_PARITY_EN
      par_r    <= par_s;
`endif
      tx_out_r <= line_s;
      busy_r   <= (state_s != IDLE) || (level_s != '0);
      ready_r  <= (level_s != LVL_FULL);
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param. Main instance: DIV=10, 8 data bits, 1 stop
// bit, FIFO depth 4. Second instance: 7 data bits, 2 stop bits.
// Accepted words go into a scoreboard queue; a line monitor pops one entry
// per frame and compares every clock of the frame against a bit model.
module tb_uart_tx_param;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = 10;
  localparam int DB     = 8;
  localparam int SB     = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P      = 1;
`else
  localparam int P      = 0;
`endif
  localparam int FRAME  = (1 + DB + P + SB) * DIV;
  localparam int SLOTS7 = 1 + 7 + P + 2;

  typedef struct {
    logic [7:0] d;
    logic       po;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_level;
  logic       podd;

  logic       v7;
  logic [6:0] d7;
  logic       r7;
  logic       o7;
  logic       b7;
  logic [2:0] l7;
  logic       podd7;

  int  checks;
  int  errors;
  int  cyc;
  int  frames;
  int  b2b;
  int  prev_start;
  bit  have_prev;
  bit  mon_en;
  sb_t sb[$];

  uart_tx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd(podd),
`endif
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut7 (
    .clk(clk), .rst(rst), .tx_valid(v7), .tx_data(d7),
`ifdef UART_TX_PARITY_EN
    .parity_odd(podd7),
`endif
    .tx_ready(r7), .tx_out(o7), .busy(b7), .fifo_level(l7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic model_bit(input sb_t e, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= DB) return e.d[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == DB + 1) return (^e.d) ^ e.po;
`endif
    return 1'b1;
  endfunction

  // Line monitor: one scoreboard entry per frame, every clock checked.
  initial begin : monitor
    sb_t e;
    int  start;
    int  errs;
    bit  aborted;
    frames = 0;
    b2b = 0;
    have_prev = 1'b0;
    prev_start = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx_out === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d expected none", cyc);
          repeat (FRAME - 1) @(negedge clk);
        end else begin
          e = sb.pop_front();
          start = cyc;
          errs = 0;
          aborted = 1'b0;
          for (int c = 0; c < FRAME; c++) begin
            if (c != 0) @(negedge clk);
            if (!mon_en || rst) begin
              aborted = 1'b1;
              break;
            end
            if (tx_out !== model_bit(e, c / DIV)) errs++;
          end
          if (!aborted) begin
            checks++;
            if (errs != 0) begin
              errors++;
              $display("FAIL frame_%02h: got %0d bad line cycles expected 0", e.d, errs);
            end
            if (have_prev && (start - prev_start == FRAME)) b2b++;
            prev_start = start;
            have_prev = 1'b1;
            frames++;
          end
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, output int acc_cyc);
    int  w;
    sb_t e;
    w = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no tx_ready for %02h expected ready", d);
      tx_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      e.d = d;
      e.po = podd;
      sb.push_back(e);
      @(negedge clk);
      acc_cyc = cyc;
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy || sb.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Checks one frame of the 7-bit instance against a literal slot pattern.
  task automatic check7(input string name, input logic [10:0] exp, input bit now);
    int w;
    int errs;
    logic [10:0] pat;
    pat = exp;
    w = 0;
    errs = 0;
    if (now) chk({name, "_b2b_start"}, {31'd0, o7}, 32'd0);
    while (o7 && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < SLOTS7 * DIV; c++) begin
      if (c != 0) @(negedge clk);
      if (o7 !== pat[c / DIV]) errs++;
    end
    chk({name, "_bad_cycles"}, errs, 32'd0);
  endtask

  initial begin : main
    vec_t tbl[6];
    int   acc[6];
    int   a;
    int   x;
    int   nb;
    int   b0;
    int   f0;

    tbl[0] = '{8'h00, 3'd1, 1'b1};
    tbl[1] = '{8'hFF, 3'd1, 1'b1};
    tbl[2] = '{8'h55, 3'd2, 1'b1};
    tbl[3] = '{8'h0F, 3'd3, 1'b1};
    tbl[4] = '{8'h81, 3'd4, 1'b0};
    tbl[5] = '{8'h3C, 3'd4, 1'b0};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    podd = 1'b0;
    v7 = 1'b0;
    d7 = 7'h00;
    podd7 = 1'b0;
    mon_en = 1'b1;

    #1;
    chk("reset_tx_out", {31'd0, tx_out}, 32'd1);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_level", {29'd0, fifo_level}, 32'd0);
    chk("reset_tx_out7", {31'd0, o7}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word 0xA5: latency and busy duration.
    send(8'hA5, a);
    chk("single_level_after_accept", {29'd0, fifo_level}, 32'd1);
    chk("single_busy_after_accept", {31'd0, busy}, 32'd1);
    chk("single_line_high_after_accept", {31'd0, tx_out}, 32'd1);
    @(negedge clk);
    chk("single_line_low_after_pop", {31'd0, tx_out}, 32'd0);
    chk("single_level_after_pop", {29'd0, fifo_level}, 32'd0);
    nb = 2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    chk("single_busy_cycles", nb, FRAME + 1);
    wait_idle();

    // Six back-to-back writes into a depth-4 FIFO.
    b0 = b2b;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].data, acc[i]);
      chk($sformatf("tbl%0d_level", i), {29'd0, fifo_level}, {29'd0, tbl[i].lvl});
      chk($sformatf("tbl%0d_ready", i), {31'd0, tx_ready}, {31'd0, tbl[i].rdy});
    end
    chk("sixth_accept_delay", acc[5] - acc[0], FRAME + 2);
    wait_idle();
    chk("six_frames_gapless", b2b - b0, 32'd5);

    // 7 data bits, 2 stop bits: 0x41 then 0x2A back to back.
    @(negedge clk);
    v7 = 1'b1;
    d7 = 7'h41;
    @(negedge clk);
    d7 = 7'h2A;
    @(negedge clk);
    v7 = 1'b0;
    d7 = 7'h7F;
`ifdef UART_TX_PARITY_EN
    check7("u7_41", 11'b11_0_1000001_0, 1'b1);
    @(negedge clk);
    check7("u7_2a", 11'b11_1_0101010_0, 1'b1);
`else
    check7("u7_41", 11'b0_11_1000001_0, 1'b1);
    @(negedge clk);
    check7("u7_2a", 11'b0_11_0101010_0, 1'b1);
`endif
    x = 0;
    while (b7 && x < 200) begin
      @(negedge clk);
      x++;
    end
    chk("u7_idle_busy", {31'd0, b7}, 32'd0);
    chk("u7_idle_level", {29'd0, l7}, 32'd0);

    // Push lands on the STOP->START pop edge with two words queued.
    wait_idle();
    b0 = b2b;
    send(8'h11, a);
    send(8'h22, x);
    send(8'h33, x);
    chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
    while (cyc < a + FRAME) @(negedge clk);
    send(8'h99, x);
    chk("pp_accept_on_pop_edge", x - a, FRAME + 1);
    chk("pp_level_unchanged", {29'd0, fifo_level}, 32'd2);
    chk("pp_next_start", {31'd0, tx_out}, 32'd0);
    wait_idle();
    chk("pp_frames_gapless", b2b - b0, 32'd3);

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07 (three ones): even gives 1, odd gives 0.
    podd = 1'b0;
    send(8'h07, a);
    repeat (1 + 9 * DIV + DIV / 2) @(negedge clk);
    chk("parity_even_bit", {31'd0, tx_out}, 32'd1);
    wait_idle();
    podd = 1'b1;
    send(8'h07, a);
    repeat (1 + 9 * DIV + DIV / 2) @(negedge clk);
    chk("parity_odd_bit", {31'd0, tx_out}, 32'd0);
    wait_idle();
    podd = 1'b0;
`endif

    // Reset mid-frame with a second word queued.
    f0 = frames;
    send(8'h00, a);
    send(8'hF0, x);
    while (cyc < a + 36) @(negedge clk);
    chk("pre_reset_line_low", {31'd0, tx_out}, 32'd0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset_tx_out", {31'd0, tx_out}, 32'd1);
    chk("midreset_level", {29'd0, fifo_level}, 32'd0);
    chk("midreset_ready", {31'd0, tx_ready}, 32'd1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_line", {31'd0, tx_out}, 32'd1);
    mon_en = 1'b1;
    send(8'h3C, a);
    wait_idle();
    chk("post_reset_frames", frames - f0, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
